// File: rtl/psg_mix_pkg.sv
// Shared types and constants for the PSG audio mixer slice.
package psg_mix_pkg;

    // Stereo placement of the three PSG channels.
    typedef enum logic [1:0] {
        MONO = 2'd0,
        ABC  = 2'd1,
        ACB  = 2'd2,
        CBA  = 2'd3
    } stereo_mode_t;

    // Width of one mixed sample: 2*255 + 255 = 765 fits in 10 bits.
    localparam int MIX_W = 10;

    // Width of the output PCM words.
    localparam int PCM_W = 16;

    // Scale factor that stretches the 0..765 average onto 0..65025.
    localparam int PCM_SCALE = 85;

endpackage

// File: rtl/psg_mix_accum.sv
// One box-car averaging channel: accumulates mixed samples, then divides
// by the window length and scales the result to 16-bit PCM.
module psg_mix_accum
    import psg_mix_pkg::*;
#(
    parameter int DECIM_LOG2 = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ce_i,
    input  logic             complete_i,
    input  logic [MIX_W-1:0] mix_i,
    output logic [PCM_W-1:0] pcm_o
);

    // The accumulator holds at most 2^DECIM_LOG2 samples of 765, so this
    // width can never overflow.
    localparam int ACC_W = MIX_W + DECIM_LOG2;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] total;

    // Running total including the current sample; on the completing CE the
    // window restarts from zero, otherwise the total is carried forward.
    always_comb begin
        total = acc_q + ACC_W'(mix_i);
        acc_d = acc_q;
        if (ce_i) begin
            acc_d = complete_i ? '0 : total;
        end
    end

    // The shifted total is the window average (at most 765), so narrowing
    // it to 16 bits before scaling loses nothing.
    assign pcm_o = PCM_W'(total >> DECIM_LOG2) * PCM_W'(PCM_SCALE);

    // Accumulator register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/psg_audio_mixer.sv
// PSG stereo mixer: matrixes channels A/B/C into left/right, averages a
// window of CE samples and offers the result over a valid/ready handshake.
module psg_audio_mixer
    import psg_mix_pkg::*;
#(
    parameter int DECIM_LOG2 = 5
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CE,
    input  logic [7:0]  CHANNEL_A,
    input  logic [7:0]  CHANNEL_B,
    input  logic [7:0]  CHANNEL_C,
    input  logic [1:0]  STEREO_MODE,
    input  logic        MUTE,
    output logic [15:0] SAMPLE_L,
    output logic [15:0] SAMPLE_R,
    output logic        SAMPLE_VALID,
    input  logic        SAMPLE_READY,
    output logic        OVERRUN,
    input  logic        OVERRUN_CLR
);

    logic [MIX_W-1:0] a1, b1, c1, a2, b2, c2;
    logic [MIX_W-1:0] mixL, mixR;

    logic [DECIM_LOG2-1:0] cnt_q, cnt_d;
    logic                  complete;

    logic [PCM_W-1:0] pcmL, pcmR;

    logic [PCM_W-1:0] sampleL_q, sampleL_d;
    logic [PCM_W-1:0] sampleR_q, sampleR_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    // Stereo matrix: the channel placed on one side counts double there,
    // the centre channel is shared once by both sides; mute zeroes the mix.
    always_comb begin
        a1 = MIX_W'(CHANNEL_A);
        b1 = MIX_W'(CHANNEL_B);
        c1 = MIX_W'(CHANNEL_C);
        a2 = a1 << 1;
        b2 = b1 << 1;
        c2 = c1 << 1;
        mixL = '0;
        mixR = '0;
        case (stereo_mode_t'(STEREO_MODE))
            MONO: begin
                mixL = a1 + b1 + c1;
                mixR = a1 + b1 + c1;
            end
            ABC: begin
                mixL = a2 + b1;
                mixR = c2 + b1;
            end
            ACB: begin
                mixL = a2 + c1;
                mixR = b2 + c1;
            end
            CBA: begin
                mixL = c2 + b1;
                mixR = a2 + b1;
            end
            default: begin
                mixL = '0;
                mixR = '0;
            end
        endcase
        if (MUTE) begin
            mixL = '0;
            mixR = '0;
        end
    end

    // Sample counter; the window closes on the CE that finds it all ones,
    // and the natural wrap restarts the next window at zero.
    always_comb begin
        complete = CE && (cnt_q == '1);
        cnt_d    = CE ? cnt_q + DECIM_LOG2'(1) : cnt_q;
    end

    psg_mix_accum #(.DECIM_LOG2(DECIM_LOG2)) u_accumL (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .ce_i       (CE),
        .complete_i (complete),
        .mix_i      (mixL),
        .pcm_o      (pcmL)
    );

    psg_mix_accum #(.DECIM_LOG2(DECIM_LOG2)) u_accumR (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .ce_i       (CE),
        .complete_i (complete),
        .mix_i      (mixR),
        .pcm_o      (pcmR)
    );

    // Output handshake: a finished window loads only if the slot is free or
    // being accepted this cycle, otherwise it is dropped and flagged; an
    // overrun event beats a simultaneous clear.
    always_comb begin
        sampleL_d = sampleL_q;
        sampleR_d = sampleR_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (OVERRUN_CLR) begin
            overrun_d = 1'b0;
        end
        if (complete) begin
            if (!valid_q || SAMPLE_READY) begin
                sampleL_d = pcmL;
                sampleR_d = pcmR;
                valid_d   = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && SAMPLE_READY) begin
            valid_d = 1'b0;
        end
    end

    // Counter and output registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q     <= '0;
            sampleL_q <= '0;
            sampleR_q <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sampleL_q <= sampleL_d;
            sampleR_q <= sampleR_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign SAMPLE_L     = sampleL_q;
    assign SAMPLE_R     = sampleR_q;
    assign SAMPLE_VALID = valid_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_psg_audio_mixer.sv
// Directed testbench for psg_audio_mixer with a 4-sample averaging window.
module tb_psg_audio_mixer;
    import psg_mix_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CE;
    logic [7:0]  CHANNEL_A;
    logic [7:0]  CHANNEL_B;
    logic [7:0]  CHANNEL_C;
    logic [1:0]  STEREO_MODE;
    logic        MUTE;
    logic [15:0] SAMPLE_L;
    logic [15:0] SAMPLE_R;
    logic        SAMPLE_VALID;
    logic        SAMPLE_READY;
    logic        OVERRUN;
    logic        OVERRUN_CLR;

    int testsRun    = 0;
    int testsFailed = 0;

    // 100 MHz free-running clock.
    always #5 CLK = ~CLK;

    psg_audio_mixer #(.DECIM_LOG2(2)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .CE           (CE),
        .CHANNEL_A    (CHANNEL_A),
        .CHANNEL_B    (CHANNEL_B),
        .CHANNEL_C    (CHANNEL_C),
        .STEREO_MODE  (STEREO_MODE),
        .MUTE         (MUTE),
        .SAMPLE_L     (SAMPLE_L),
        .SAMPLE_R     (SAMPLE_R),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_READY (SAMPLE_READY),
        .OVERRUN      (OVERRUN),
        .OVERRUN_CLR  (OVERRUN_CLR)
    );

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Present one CE sample, then optionally idle for some cycles; returns
    // 1 time unit after the last clock edge so outputs can be sampled.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] c, input stereo_mode_t mode,
                                 input int gap);
        CHANNEL_A   = a;
        CHANNEL_B   = b;
        CHANNEL_C   = c;
        STEREO_MODE = mode;
        CE          = 1'b1;
        @(posedge CLK);
        #1;
        CE = 1'b0;
        for (int i = 0; i < gap; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // A full four-CE window of constant inputs.
    task automatic runWindow(input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] c, input stereo_mode_t mode);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(a, b, c, mode, 0);
        end
    endtask

    // One clock with CE low.
    task automatic idleCycle();
        @(posedge CLK);
        #1;
    endtask

    // Hard time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence; every expectation is worked out by hand from the
    // mix matrix, the 4-sample average and the x85 scale.
    initial begin
        RESET        = 1'b1;
        CE           = 1'b0;
        CHANNEL_A    = 8'h00;
        CHANNEL_B    = 8'h00;
        CHANNEL_C    = 8'h00;
        STEREO_MODE  = 2'd0;
        MUTE         = 1'b0;
        SAMPLE_READY = 1'b0;
        OVERRUN_CLR  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("reset_L", SAMPLE_L, 16'h0000);
        checkOutput("reset_R", SAMPLE_R, 16'h0000);
        checkOutput("reset_valid", 16'(SAMPLE_VALID), 16'h0000);
        checkOutput("reset_overrun", 16'(OVERRUN), 16'h0000);
        RESET = 1'b0;
        idleCycle();

        // Mono full scale: 765 average * 85 = 65025 = 0xFE01.
        SAMPLE_READY = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 8'hFF, 8'hFF, MONO, 0);
        checkOutput("mono_valid_early", 16'(SAMPLE_VALID), 16'h0000);
        applyStimulus(8'hFF, 8'hFF, 8'hFF, MONO, 0);
        checkOutput("mono_L", SAMPLE_L, 16'hFE01);
        checkOutput("mono_R", SAMPLE_R, 16'hFE01);
        checkOutput("mono_valid", 16'(SAMPLE_VALID), 16'h0001);
        idleCycle();
        checkOutput("mono_valid_pulse", 16'(SAMPLE_VALID), 16'h0000);

        // ABC: L = 2*0x10 + 0x20 = 64 -> 0x1540, R = 0x20 = 32 -> 0x0AA0.
        runWindow(8'h10, 8'h20, 8'h00, ABC);
        checkOutput("abc_L", SAMPLE_L, 16'h1540);
        checkOutput("abc_R", SAMPLE_R, 16'h0AA0);
        idleCycle();
        checkOutput("abc_valid_drop", 16'(SAMPLE_VALID), 16'h0000);

        // ACB: L = 2*0x10 + 0x00 = 32, R = 2*0x20 + 0 = 64.
        runWindow(8'h10, 8'h20, 8'h00, ACB);
        checkOutput("acb_L", SAMPLE_L, 16'h0AA0);
        checkOutput("acb_R", SAMPLE_R, 16'h1540);
        idleCycle();

        // CBA: L = 2*0x08 + 0x20 = 48 -> 4080, R = 2*0x10 + 0x20 = 64.
        runWindow(8'h10, 8'h20, 8'h08, CBA);
        checkOutput("cba_L", SAMPLE_L, 16'h0FF0);
        checkOutput("cba_R", SAMPLE_R, 16'h1540);
        idleCycle();

        // Mute zeroes every sample of the window.
        MUTE = 1'b1;
        runWindow(8'hFF, 8'hFF, 8'hFF, MONO);
        MUTE = 1'b0;
        checkOutput("mute_L", SAMPLE_L, 16'h0000);
        checkOutput("mute_valid", 16'(SAMPLE_VALID), 16'h0001);
        idleCycle();

        // Alternating A = 0,4,0,4 averages to 2 -> 0x00AA, back to back.
        applyStimulus(8'h00, 8'h00, 8'h00, MONO, 0);
        applyStimulus(8'h04, 8'h00, 8'h00, MONO, 0);
        applyStimulus(8'h00, 8'h00, 8'h00, MONO, 0);
        checkOutput("alt_valid_early", 16'(SAMPLE_VALID), 16'h0000);
        applyStimulus(8'h04, 8'h00, 8'h00, MONO, 0);
        checkOutput("alt_L", SAMPLE_L, 16'h00AA);
        checkOutput("alt_R", SAMPLE_R, 16'h00AA);
        idleCycle();

        // Same pattern with idle cycles between CEs gives the same result.
        applyStimulus(8'h00, 8'h00, 8'h00, MONO, 3);
        applyStimulus(8'h04, 8'h00, 8'h00, MONO, 3);
        applyStimulus(8'h00, 8'h00, 8'h00, MONO, 3);
        checkOutput("gap_valid_early", 16'(SAMPLE_VALID), 16'h0000);
        applyStimulus(8'h04, 8'h00, 8'h00, MONO, 0);
        checkOutput("gap_L", SAMPLE_L, 16'h00AA);
        checkOutput("gap_valid", 16'(SAMPLE_VALID), 16'h0001);
        idleCycle();

        // Consumer stalls across two windows: the first is held, the second
        // is dropped and flagged.
        SAMPLE_READY = 1'b0;
        runWindow(8'h10, 8'h20, 8'h00, ABC);
        checkOutput("stall_first_L", SAMPLE_L, 16'h1540);
        runWindow(8'hFF, 8'hFF, 8'hFF, MONO);
        checkOutput("stall_held_L", SAMPLE_L, 16'h1540);
        checkOutput("stall_held_R", SAMPLE_R, 16'h0AA0);
        checkOutput("stall_valid", 16'(SAMPLE_VALID), 16'h0001);
        checkOutput("stall_overrun", 16'(OVERRUN), 16'h0001);
        SAMPLE_READY = 1'b1;
        idleCycle();
        checkOutput("stall_accept", 16'(SAMPLE_VALID), 16'h0000);
        checkOutput("overrun_sticky", 16'(OVERRUN), 16'h0001);
        SAMPLE_READY = 1'b0;
        OVERRUN_CLR  = 1'b1;
        idleCycle();
        OVERRUN_CLR  = 1'b0;
        checkOutput("overrun_clr", 16'(OVERRUN), 16'h0000);

        // Clear held high through a fresh overrun: the set must win.
        runWindow(8'h10, 8'h20, 8'h00, ABC);
        OVERRUN_CLR = 1'b1;
        runWindow(8'hFF, 8'hFF, 8'hFF, MONO);
        checkOutput("overrun_set_wins", 16'(OVERRUN), 16'h0001);
        OVERRUN_CLR  = 1'b0;
        SAMPLE_READY = 1'b1;
        idleCycle();
        OVERRUN_CLR = 1'b1;
        idleCycle();
        OVERRUN_CLR = 1'b0;

        // Accept on the exact completing CE: new sample replaces the old one.
        SAMPLE_READY = 1'b0;
        runWindow(8'h10, 8'h20, 8'h00, ABC);
        for (int i = 0; i < 3; i++) applyStimulus(8'hFF, 8'hFF, 8'hFF, MONO, 0);
        SAMPLE_READY = 1'b1;
        applyStimulus(8'hFF, 8'hFF, 8'hFF, MONO, 0);
        checkOutput("swap_L", SAMPLE_L, 16'hFE01);
        checkOutput("swap_R", SAMPLE_R, 16'hFE01);
        checkOutput("swap_valid", 16'(SAMPLE_VALID), 16'h0001);
        checkOutput("swap_overrun", 16'(OVERRUN), 16'h0000);
        idleCycle();
        checkOutput("swap_accept", 16'(SAMPLE_VALID), 16'h0000);

        // Asynchronous reset mid-window with a sample still held:
        // 3*0x11 = 51 -> 4335 = 0x10EF before reset.
        SAMPLE_READY = 1'b0;
        runWindow(8'h11, 8'h11, 8'h11, MONO);
        checkOutput("prereset_L", SAMPLE_L, 16'h10EF);
        applyStimulus(8'h11, 8'h11, 8'h11, MONO, 0);
        applyStimulus(8'h11, 8'h11, 8'h11, MONO, 0);
        #2;
        RESET = 1'b1;
        #1;
        checkOutput("async_rst_L", SAMPLE_L, 16'h0000);
        checkOutput("async_rst_R", SAMPLE_R, 16'h0000);
        checkOutput("async_rst_valid", 16'(SAMPLE_VALID), 16'h0000);
        #2;
        RESET = 1'b0;

        // A full fresh window of 0x20 mono is needed: 32 -> 0x0AA0.
        SAMPLE_READY = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(8'h20, 8'h00, 8'h00, MONO, 0);
        checkOutput("postrst_valid_early", 16'(SAMPLE_VALID), 16'h0000);
        applyStimulus(8'h20, 8'h00, 8'h00, MONO, 0);
        checkOutput("postrst_L", SAMPLE_L, 16'h0AA0);
        checkOutput("postrst_R", SAMPLE_R, 16'h0AA0);
        checkOutput("postrst_valid", 16'(SAMPLE_VALID), 16'h0001);
        idleCycle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
